rasresp: RTL and testbench

DRAM-side responder for one memory bank. It decodes the active-low RAS/chip select, CAS and write-enable strobes that the memory controller's RAS/CAS generators drive. It behaves as a small synchronous DRAM bank: it latches the row and column from the multiplexed address, returns or stores data, and performs CAS-before-RAS refresh. It also flags strobe-timing violations, so the bank generators can be exercised and checked in system simulation.

---
 rtl/rasresp_if.sv | 45 ++++
 rtl/rasresp.sv | 182 ++++++++++++++++++
 tb/tb_rasresp.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rasresp_if.sv
// rasresp_if: strobe/address/data bundle between a RAS/CAS bank generator and
// the rasresp DRAM-side responder.
//   master modport: the generator side; drives rasl, casl, wel, ma, din and
//                   observes the responder's data and status outputs.
//   slave modport : the responder side (rasresp).
// Signals:
//   rasl, casl, wel : active-low RAS/bank select, CAS and write enable
//   ma              : multiplexed row/column address, max(ROW_W, COL_W) bits
//   din / dout      : write data / read data
//   doe             : read data valid / output enable
//   row_open        : a row is active; open_row holds its address
//   trcd_err        : sticky tRCD violation flag
//   trp_err         : sticky tRP violation flag
//   refresh_cnt     : CBR refresh count, wraps at 255
`timescale 1ns/1ps
interface rasresp_if #(
    parameter int unsigned ROW_W  = 4,
    parameter int unsigned COL_W  = 4,
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned MA_W = (ROW_W > COL_W) ? ROW_W : COL_W;

    logic              rasl;
    logic              casl;
    logic              wel;
    logic [MA_W-1:0]   ma;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              doe;
    logic              row_open;
    logic [ROW_W-1:0]  open_row;
    logic              trcd_err;
    logic              trp_err;
    logic [7:0]        refresh_cnt;

    modport master (
        output rasl, casl, wel, ma, din,
        input  dout, doe, row_open, open_row, trcd_err, trp_err, refresh_cnt
    );

    modport slave (
        input  rasl, casl, wel, ma, din,
        output dout, doe, row_open, open_row, trcd_err, trp_err, refresh_cnt
    );
endinterface

// File: rtl/rasresp.sv
// rasresp: synchronous single-bank DRAM responder. Decodes active-low RAS/CAS/WE
// strobes, latches row at RAS fall and column at CAS fall, performs reads with a
// CL-cycle pipeline and same-edge writes, counts CAS-before-RAS refreshes and
// raises sticky tRCD/tRP violation flags.
// Ports:
//   sys_clk : single clock, strobes sampled on the rising edge
//   reset   : synchronous active-high reset
//   bus     : rasresp_if slave modport (strobes, address, data, status)
`timescale 1ns/1ps
module rasresp #(
    parameter int unsigned ROW_W  = 4,
    parameter int unsigned COL_W  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TRCD   = 2,
    parameter int unsigned TRP    = 3,
    parameter int unsigned CL     = 2   // legal range 1..7
) (
    input logic       sys_clk,
    input logic       reset,
    rasresp_if.slave  bus
);
    localparam int unsigned AW    = ROW_W + COL_W;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned TW    = 8;
    localparam int unsigned CW    = 3;

    typedef enum logic [1:0] {StIdle, StActive, StCbr, StPre} state_e;

    state_e            state_q, state_d;
    logic              ras_prev_q, cas_prev_q;
    logic [TW-1:0]     tcnt_q, tcnt_d, tcnt_inc;
    logic              rd_busy_q, rd_busy_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              doe_q, doe_d;
    logic              row_open_q, row_open_d;
    logic [ROW_W-1:0]  open_row_q, open_row_d;
    logic              trcd_err_q, trcd_err_d;
    logic              trp_err_q, trp_err_d;
    logic [7:0]        refresh_q, refresh_d;
    logic              mem_we;
    logic [AW-1:0]     acc_addr;
    logic              ras_fall, ras_rise, cas_fall;

    logic [DATA_W-1:0] mem [DEPTH];

    assign ras_fall = ras_prev_q & ~bus.rasl;
    assign ras_rise = ~ras_prev_q & bus.rasl;
    assign cas_fall = cas_prev_q & ~bus.casl;
    assign acc_addr = {open_row_q, bus.ma[COL_W-1:0]};

    // Shared timer: cycles since RAS fall in ACTIVE/CBR, cycles since RAS rise in
    // PRE. tcnt_inc is the elapsed-cycle count as of the current edge.
    assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + TW'(1);

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_inc;
        rd_busy_d  = rd_busy_q;
        rd_cnt_d   = rd_cnt_q;
        rd_addr_d  = rd_addr_q;
        dout_d     = dout_q;
        doe_d      = doe_q & ~bus.casl;
        row_open_d = row_open_q;
        open_row_d = open_row_q;
        trcd_err_d = trcd_err_q;
        trp_err_d  = trp_err_q;
        refresh_d  = refresh_q;
        mem_we     = 1'b0;

        // Read pipeline: dout loads CL edges after the CAS fall; doe only if CAS
        // is still low at that edge.
        if (rd_busy_q) begin
            if (rd_cnt_q == CW'(CL)) begin
                rd_busy_d = 1'b0;
                dout_d    = mem[rd_addr_q];
                doe_d     = ~bus.casl;
            end else begin
                rd_cnt_d = rd_cnt_q + CW'(1);
            end
        end

        unique case (state_q)
            StIdle, StPre: begin
                if (state_q == StPre && tcnt_inc >= TW'(TRP)) begin
                    state_d = StIdle;
                end
                if (ras_fall) begin
                    if (state_q == StPre && tcnt_inc < TW'(TRP)) begin
                        trp_err_d = 1'b1;
                    end
                    tcnt_d = '0;
                    if (bus.casl) begin
                        state_d    = StActive;
                        row_open_d = 1'b1;
                        open_row_d = bus.ma[ROW_W-1:0];
                    end else begin
                        // CAS already low: CBR refresh, no row access
                        state_d   = StCbr;
                        refresh_d = refresh_q + 8'd1;
                    end
                end
            end
            StActive, StCbr: begin
                if (ras_rise) begin
                    // Precharge wins over a same-edge CAS fall and cancels any read
                    state_d    = StPre;
                    tcnt_d     = '0;
                    row_open_d = 1'b0;
                    rd_busy_d  = 1'b0;
                    dout_d     = dout_q;
                    doe_d      = 1'b0;
                end else if (state_q == StActive && cas_fall) begin
                    if (tcnt_inc < TW'(TRCD)) begin
                        trcd_err_d = 1'b1;
                    end
                    // A new access discards any older pending read
                    rd_busy_d = 1'b0;
                    dout_d    = dout_q;
                    doe_d     = 1'b0;
                    if (!bus.wel) begin
                        mem_we = 1'b1;
                    end else begin
                        rd_busy_d = 1'b1;
                        rd_cnt_d  = CW'(1);
                        rd_addr_d = acc_addr;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ras_prev_q <= 1'b1;
            cas_prev_q <= 1'b1;
            tcnt_q     <= '0;
            rd_busy_q  <= 1'b0;
            rd_cnt_q   <= '0;
            rd_addr_q  <= '0;
            dout_q     <= '0;
            doe_q      <= 1'b0;
            row_open_q <= 1'b0;
            open_row_q <= '0;
            trcd_err_q <= 1'b0;
            trp_err_q  <= 1'b0;
            refresh_q  <= '0;
        end else begin
            state_q    <= state_d;
            ras_prev_q <= bus.rasl;
            cas_prev_q <= bus.casl;
            tcnt_q     <= tcnt_d;
            rd_busy_q  <= rd_busy_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_addr_q  <= rd_addr_d;
            dout_q     <= dout_d;
            doe_q      <= doe_d;
            row_open_q <= row_open_d;
            open_row_q <= open_row_d;
            trcd_err_q <= trcd_err_d;
            trp_err_q  <= trp_err_d;
            refresh_q  <= refresh_d;
        end
    end

    // Storage is not reset; writes are blocked while reset is asserted.
    always_ff @(posedge sys_clk) begin
        if (mem_we && !reset) begin
            mem[acc_addr] <= bus.din;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.doe         = doe_q;
    assign bus.row_open    = row_open_q;
    assign bus.open_row    = open_row_q;
    assign bus.trcd_err    = trcd_err_q;
    assign bus.trp_err     = trp_err_q;
    assign bus.refresh_cnt = refresh_q;
endmodule

// File: tb/tb_rasresp.sv
// tb_rasresp: directed plus randomized stimulus for rasresp, checked against a
// transaction-level model (word array, cycle stamps of strobe edges, sticky flags).
`timescale 1ns/1ps
module tb_rasresp;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned COL_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TRCD   = 2;
    localparam int unsigned TRP    = 3;
    localparam int unsigned CL     = 2;

    logic sys_clk = 1'b0;
    logic reset;

    rasresp_if #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W)) bus ();

    rasresp #(
        .ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W),
        .TRCD(TRCD), .TRP(TRP), .CL(CL)
    ) dut (
        .sys_clk(sys_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fall_cyc = 0;
    int rise_cyc = -100;

    logic              exp_trcd, exp_trp;
    logic [7:0]        exp_ref;
    logic [DATA_W-1:0] exp_dout;
    logic [ROW_W-1:0]  cur_row;
    logic [DATA_W-1:0] ref_mem [256];
    bit                written [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_trcd"}, bus.trcd_err, exp_trcd);
        check({tag, "_trp"}, bus.trp_err, exp_trp);
        check({tag, "_ref"}, bus.refresh_cnt, exp_ref);
    endtask

    task automatic ras_open(input logic [ROW_W-1:0] row);
        bus.ma   = row;
        bus.casl = 1'b1;
        bus.rasl = 1'b0;
        step();
        if (cyc - rise_cyc < int'(TRP)) exp_trp = 1'b1;
        fall_cyc = cyc;
        cur_row  = row;
        check("row_open", bus.row_open, 1);
        check("open_row", bus.open_row, row);
    endtask

    task automatic ras_close();
        bus.rasl = 1'b1;
        bus.casl = 1'b1;
        step();
        rise_cyc = cyc;
        check("row_closed", bus.row_open, 0);
        check("doe_closed", bus.doe, 0);
    endtask

    task automatic do_write(input logic [COL_W-1:0] col, input logic [DATA_W-1:0] data);
        bus.ma   = col;
        bus.wel  = 1'b0;
        bus.din  = data;
        bus.casl = 1'b0;
        step();
        if (cyc - fall_cyc < int'(TRCD)) exp_trcd = 1'b1;
        ref_mem[{cur_row, col}] = data;
        written[{cur_row, col}] = 1'b1;
        bus.casl = 1'b1;
        bus.wel  = 1'b1;
        step();
        check("wr_doe", bus.doe, 0);
    endtask

    // hold: number of edges (from the CAS fall edge) that sample casl low
    task automatic do_read(input logic [COL_W-1:0] col, input int hold);
        logic [DATA_W-1:0] want;
        bus.ma   = col;
        bus.wel  = 1'b1;
        bus.casl = 1'b0;
        step();
        if (cyc - fall_cyc < int'(TRCD)) exp_trcd = 1'b1;
        want = ref_mem[{cur_row, col}];
        for (int k = 1; k <= int'(CL) + 2; k++) begin
            if (k >= hold) bus.casl = 1'b1;
            step();
            if (k < int'(CL)) check("rd_doe_early", bus.doe, 0);
            if (k == int'(CL)) begin
                check("rd_dout", bus.dout, want);
                check("rd_doe", bus.doe, (int'(CL) < hold) ? 1 : 0);
                check("rd_row_open", bus.row_open, 1);
                exp_dout = want;
            end
        end
        check("rd_doe_end", bus.doe, 0);
    endtask

    task automatic cbr();
        bus.casl = 1'b0;
        step();
        check("cbr_pre_row", bus.row_open, 0);
        bus.rasl = 1'b0;
        step();
        if (cyc - rise_cyc < int'(TRP)) exp_trp = 1'b1;
        exp_ref = exp_ref + 8'd1;
        check("cbr_cnt", bus.refresh_cnt, exp_ref);
        check("cbr_row", bus.row_open, 0);
        check("cbr_doe", bus.doe, 0);
        bus.rasl = 1'b1;
        bus.casl = 1'b1;
        step();
        rise_cyc = cyc;
        check("cbr_doe_after", bus.doe, 0);
    endtask

    initial begin
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] old;

        reset    = 1'b1;
        bus.rasl = 1'b1;
        bus.casl = 1'b1;
        bus.wel  = 1'b1;
        bus.ma   = '0;
        bus.din  = '0;
        exp_trcd = 1'b0;
        exp_trp  = 1'b0;
        exp_ref  = '0;
        exp_dout = '0;
        cur_row  = '0;
        for (int i = 0; i < 256; i++) written[i] = 1'b0;
        idle(2);
        reset = 1'b0;
        check("rst_dout", bus.dout, 0);
        check("rst_doe", bus.doe, 0);
        check("rst_row_open", bus.row_open, 0);
        check("rst_open_row", bus.open_row, 0);
        check_flags("rst");
        step();

        // Read after write, exactly TRCD and exactly TRP spacing
        ras_open(4'd3);
        idle(1);
        do_write(4'd5, 16'hA55A);
        ras_close();
        idle(2);
        ras_open(4'd3);
        idle(1);
        do_read(4'd5, int'(CL) + 1);
        check("raw_dout", exp_dout, 16'hA55A);
        check_flags("raw");
        ras_close();
        idle(2);

        // Page mode
        ras_open(4'd9);
        idle(1);
        do_write(4'd1, 16'd11);
        do_write(4'd2, 16'd22);
        do_write(4'd3, 16'd33);
        ras_close();
        idle(2);
        ras_open(4'd9);
        idle(1);
        do_read(4'd1, int'(CL) + 1);
        do_read(4'd2, int'(CL) + 1);
        do_read(4'd3, int'(CL) + 2);
        ras_close();
        idle(2);

        // CBR refresh x3, then memory unchanged
        cbr();
        idle(2);
        cbr();
        idle(2);
        cbr();
        idle(2);
        check_flags("cbr");
        ras_open(4'd9);
        idle(1);
        do_read(4'd2, int'(CL) + 1);
        check("cbr_mem", exp_dout, 16'd22);
        ras_close();

        // Randomized legal traffic
        for (int it = 0; it < 20; it++) begin
            idle(2 + int'($urandom_range(0, 1)));
            row = 4'($urandom_range(0, 15));
            ras_open(row);
            idle(int'($urandom_range(1, 2)));
            for (int a = 0; a < int'($urandom_range(1, 4)); a++) begin
                col = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1 && written[{row, col}])
                    do_read(col, int'($urandom_range(1, CL + 2)));
                else
                    do_write(col, 16'($urandom));
                if ($urandom_range(0, 1) == 1) step();
            end
            ras_close();
            check_flags("rand");
        end

        // Precharge priority: RAS rise with a same-edge write CAS fall
        idle(2);
        ras_open(4'd9);
        idle(1);
        bus.rasl = 1'b1;
        bus.casl = 1'b0;
        bus.wel  = 1'b0;
        bus.ma   = 4'd2;
        bus.din  = ~ref_mem[{4'd9, 4'd2}];
        step();
        rise_cyc = cyc;
        check("prio_row", bus.row_open, 0);
        bus.casl = 1'b1;
        bus.wel  = 1'b1;
        step();
        check("prio_doe", bus.doe, 0);
        idle(1);
        ras_open(4'd9);
        idle(1);
        do_read(4'd2, int'(CL) + 1);
        ras_close();
        idle(2);

        // Read cancelled by RAS rise one cycle after the CAS fall
        ras_open(4'd9);
        idle(1);
        old = exp_dout;
        bus.ma   = 4'd1;
        bus.wel  = 1'b1;
        bus.casl = 1'b0;
        step();
        bus.rasl = 1'b1;
        bus.casl = 1'b1;
        step();
        rise_cyc = cyc;
        for (int k = 0; k < int'(CL) + 1; k++) begin
            check("cancel_doe", bus.doe, 0);
            check("cancel_dout", bus.dout, old);
            step();
        end
        check_flags("cancel");

        // tRCD violation: CAS fall one cycle after RAS fall, access still done
        ras_open(4'd9);
        do_read(4'd3, int'(CL) + 1);
        check("trcd_set", bus.trcd_err, 1);
        check_flags("trcd");
        ras_close();

        // tRP violation: RAS fall two cycles after RAS rise, row still opens
        idle(1);
        ras_open(4'd3);
        check("trp_set", bus.trp_err, 1);
        idle(1);
        do_read(4'd5, int'(CL) + 1);
        ras_close();
        idle(4);
        check_flags("sticky");

        // Reset during the CL wait
        ras_open(4'd9);
        idle(1);
        bus.ma   = 4'd1;
        bus.wel  = 1'b1;
        bus.casl = 1'b0;
        step();
        reset = 1'b1;
        step();
        exp_trcd = 1'b0;
        exp_trp  = 1'b0;
        exp_ref  = '0;
        rise_cyc = -100;
        check("mid_rst_doe", bus.doe, 0);
        check("mid_rst_dout", bus.dout, 0);
        check("mid_rst_row", bus.row_open, 0);
        check_flags("mid_rst");
        reset    = 1'b0;
        bus.rasl = 1'b1;
        bus.casl = 1'b1;
        for (int k = 0; k < int'(CL) + 1; k++) begin
            step();
            check("post_rst_doe", bus.doe, 0);
        end
        // Idle after reset: immediate RAS fall must not flag tRP
        ras_open(4'd3);
        idle(1);
        do_read(4'd5, int'(CL) + 1);
        ras_close();
        check_flags("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
